seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture_if.sv | 21 ++
 rtl/seg_capture.sv | 142 ++++++++++++++
 tb/tb_seg_capture.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_capture_if.sv
// Bundle of the 7-segment scan inputs and the decoded-frame outputs of seg_capture.
// The display driver (or bench) is the master; the capture block is the slave.
interface seg_capture_if;
    logic [3:0]  seg_sel;
    logic [7:0]  seg_data;
    logic [19:0] disp_code;
    logic        frame_valid;
    logic        stable;
    logic        sel_err;
    logic        stall;

    modport master (
        output seg_sel, seg_data,
        input  disp_code, frame_valid, stable, sel_err, stall
    );

    modport slave (
        input  seg_sel, seg_data,
        output disp_code, frame_valid, stable, sel_err, stall
    );
endinterface

// File: rtl/seg_capture.sv
// Snoops a multiplexed 4-digit 7-segment scan, rebuilds the displayed frame as
// 5-bit character codes, and reports frame stability, select errors and stalled scans.
module seg_capture #(
    parameter int STABLE_FRAMES = 3,
    parameter int STALL_CYCLES  = 100000
) (
    input  logic          clk,
    input  logic          rst,
    seg_capture_if.slave  bus
);

    localparam logic [3:0]  STAB_MAX = 4'(STABLE_FRAMES);
    localparam logic [19:0] IDLE_MAX = 20'(STALL_CYCLES);
    localparam logic [4:0]  BLANK    = 5'd15;

    logic [3:0]       sel_p1;
    logic [7:0]       data_p1;
    logic [3:0]       sel_p2;
    logic [3:0][4:0]  shadow;
    logic [3:0]       seen;
    logic [3:0]       stab_cnt;
    logic [19:0]      idle_cnt;
    logic [19:0]      disp_code;
    logic             frame_valid;
    logic             stable;
    logic             sel_err;
    logic             stall;

    logic [4:0]  code_p1;
    logic        one_hot;
    logic        multi_hot;
    logic        sel_chg;
    logic [19:0] idle_inc;
    logic [19:0] idle_nxt;
    logic        stall_nxt;
    logic        publish;
    logic [3:0]  stab_nxt;
    logic [3:0]  seen_nxt;

    // The dp bit is a don't-care in every pattern.
    function automatic logic [4:0] seg_decode(input logic [7:0] p);
        logic [4:0] c;
        casez (p)
            8'b?011_1111: c = 5'd0;
            8'b?000_0110: c = 5'd1;
            8'b?101_1011: c = 5'd2;
            8'b?100_1111: c = 5'd3;
            8'b?110_0110: c = 5'd4;
            8'b?110_1101: c = 5'd5;
            8'b?111_1101: c = 5'd6;
            8'b?000_0111: c = 5'd7;
            8'b?111_1111: c = 5'd8;
            8'b?110_1111: c = 5'd9;
            8'b?011_1101: c = 5'd11;
            8'b?111_1000: c = 5'd12;
            8'b?111_0111: c = 5'd13;
            8'b?111_1100: c = 5'd14;
            8'b?000_0000: c = 5'd15;
            8'b?011_1001: c = 5'd16;
            8'b?001_1110: c = 5'd17;
            default:      c = 5'd31;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] stab_sat_inc(input logic [3:0] v);
        return (v >= STAB_MAX) ? STAB_MAX : v + 4'd1;
    endfunction

    function automatic logic [19:0] idle_sat_inc(input logic [19:0] v);
        return (v >= IDLE_MAX) ? IDLE_MAX : v + 20'd1;
    endfunction

    // S1 -> shadow/seen: decode and classify the registered sample
    always_comb begin
        code_p1   = seg_decode(data_p1);
        multi_hot = (sel_p1 & (sel_p1 - 4'd1)) != 4'd0;
        one_hot   = (sel_p1 != 4'd0) && !multi_hot;
        sel_chg   = sel_p1 != sel_p2;
        idle_inc  = idle_sat_inc(idle_cnt);
        idle_nxt  = sel_chg ? 20'd0 : idle_inc;
        stall_nxt = !sel_chg && (idle_inc == IDLE_MAX);
        publish   = (seen == 4'hF) && !multi_hot && !stall_nxt;

        stab_nxt = stab_cnt;
        if (stall_nxt)
            stab_nxt = 4'd0;
        else if (publish)
            stab_nxt = (shadow == disp_code) ? stab_sat_inc(stab_cnt) : 4'd1;

        // A write landing on the publish edge starts the next frame.
        seen_nxt = seen;
        if (stall_nxt || multi_hot)
            seen_nxt = 4'd0;
        else if (publish)
            seen_nxt = one_hot ? sel_p1 : 4'd0;
        else if (one_hot)
            seen_nxt = seen | sel_p1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_p1      <= 4'd0;
            data_p1     <= 8'd0;
            sel_p2      <= 4'd0;
            shadow      <= {4{BLANK}};
            seen        <= 4'd0;
            stab_cnt    <= 4'd0;
            idle_cnt    <= 20'd0;
            disp_code   <= {4{BLANK}};
            frame_valid <= 1'b0;
            stable      <= 1'b0;
            sel_err     <= 1'b0;
            stall       <= 1'b0;
        end else begin
            // input -> S1
            sel_p1  <= bus.seg_sel;
            data_p1 <= bus.seg_data;
            sel_p2  <= sel_p1;
            // S1 -> shadow/seen and publish
            for (int k = 0; k < 4; k++)
                if (one_hot && sel_p1[k])
                    shadow[k] <= code_p1;
            seen        <= seen_nxt;
            stab_cnt    <= stab_nxt;
            idle_cnt    <= idle_nxt;
            stall       <= stall_nxt;
            sel_err     <= multi_hot;
            frame_valid <= publish;
            stable      <= (stab_nxt >= STAB_MAX) && !stall_nxt;
            if (publish)
                disp_code <= shadow;
        end
    end

    assign bus.disp_code   = disp_code;
    assign bus.frame_valid = frame_valid;
    assign bus.stable      = stable;
    assign bus.sel_err     = sel_err;
    assign bus.stall       = stall;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: reset, scan capture, stability, select error,
// stall and a table-driven decode sweep, all against hand-computed expectations.
module tb_seg_capture;

    localparam logic [4:0] BL = 5'd15;

    typedef struct {
        logic [7:0] pat;
        logic [4:0] code;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    seg_capture_if bus ();

    seg_capture #(.STABLE_FRAMES(3), .STALL_CYCLES(50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int fv_cnt = 0;
    int se_cnt = 0;
    logic stab_log [64];
    int   pub_cyc  [64];
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.frame_valid) begin
            stab_log[fv_cnt % 64] <= bus.stable;
            pub_cyc[fv_cnt % 64]  <= cyc;
            fv_cnt <= fv_cnt + 1;
        end
        if (bus.sel_err) se_cnt <= se_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] pk(input logic [4:0] c3, c2, c1, c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [7:0] d, input int n);
        bus.seg_sel  = s;
        bus.seg_data = d;
        repeat (n) @(negedge clk);
    endtask

    // The last digit is shown for one cycle so the publish edge leaves seen empty.
    task automatic frame(input logic [7:0] d0, d1, d2, d3, input int hold);
        drive(4'b0001, d0, hold);
        drive(4'b0010, d1, hold);
        drive(4'b0100, d2, hold);
        drive(4'b1000, d3, 1);
        drive(4'b0000, 8'h00, 4);
    endtask

    task automatic frame_chk(input string name, input logic [7:0] d0, d1, d2, d3,
                             input logic [19:0] exp_disp, input logic exp_stable);
        int f0;
        f0 = fv_cnt;
        frame(d0, d1, d2, d3, 3);
        chk({name, " pulses"}, 32'(fv_cnt - f0), 32'd1);
        chk({name, " disp"}, 32'(bus.disp_code), 32'(exp_disp));
        chk({name, " stable"}, 32'(bus.stable), 32'(exp_stable));
    endtask

    task automatic do_reset();
        bus.seg_sel  = 4'd0;
        bus.seg_data = 8'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl [21];
        int f0, e0, c0, n;

        tbl[0]  = '{8'h3F, 5'd0};   tbl[1]  = '{8'h06, 5'd1};   tbl[2]  = '{8'h5B, 5'd2};
        tbl[3]  = '{8'h4F, 5'd3};   tbl[4]  = '{8'h66, 5'd4};   tbl[5]  = '{8'h6D, 5'd5};
        tbl[6]  = '{8'h7D, 5'd6};   tbl[7]  = '{8'h07, 5'd7};   tbl[8]  = '{8'h7F, 5'd8};
        tbl[9]  = '{8'h6F, 5'd9};   tbl[10] = '{8'h3D, 5'd11};  tbl[11] = '{8'h78, 5'd12};
        tbl[12] = '{8'h77, 5'd13};  tbl[13] = '{8'h7C, 5'd14};  tbl[14] = '{8'h00, 5'd15};
        tbl[15] = '{8'h39, 5'd16};  tbl[16] = '{8'h1E, 5'd17};  tbl[17] = '{8'h80, 5'd15};
        tbl[18] = '{8'h49, 5'd31};  tbl[19] = '{8'hBF, 5'd0};   tbl[20] = '{8'h86, 5'd1};

        bus.seg_sel  = 4'd0;
        bus.seg_data = 8'd0;
        rst = 1'b1;
        #2;
        chk("reset disp", 32'(bus.disp_code), 32'h7BDEF);
        chk("reset frame_valid", 32'(bus.frame_valid), 32'd0);
        chk("reset stable", 32'(bus.stable), 32'd0);
        chk("reset sel_err", 32'(bus.sel_err), 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Continuous scan, 10 cycles per digit, three rounds.
        f0 = fv_cnt;
        c0 = 0;
        for (int r = 0; r < 3; r++) begin
            drive(4'b0001, 8'h00, 10);
            drive(4'b0010, 8'h00, 10);
            drive(4'b0100, 8'h00, 10);
            if (r == 0) c0 = cyc;
            drive(4'b1000, 8'h06, 10);
        end
        drive(4'b0000, 8'h00, 4);
        chk("basic pulses", 32'(fv_cnt - f0), 32'd3);
        chk("basic latency", 32'(pub_cyc[f0 % 64] - c0), 32'd3);
        chk("basic stable pub1", 32'(stab_log[f0 % 64]), 32'd0);
        chk("basic stable pub2", 32'(stab_log[(f0 + 1) % 64]), 32'd0);
        chk("basic stable pub3", 32'(stab_log[(f0 + 2) % 64]), 32'd1);
        chk("basic disp", 32'(bus.disp_code), 32'(pk(5'd1, BL, BL, BL)));

        do_reset();
        frame_chk("cc f1", 8'h00, 8'h00, 8'h00, 8'h06, pk(5'd1, BL, BL, BL), 1'b0);
        frame_chk("cc f2", 8'h00, 8'h00, 8'h00, 8'h06, pk(5'd1, BL, BL, BL), 1'b0);
        frame_chk("cc f3", 8'h00, 8'h00, 8'h00, 8'h06, pk(5'd1, BL, BL, BL), 1'b1);
        frame_chk("cc chg1", 8'h00, 8'h6D, 8'h00, 8'h06, pk(5'd1, BL, 5'd5, BL), 1'b0);
        frame_chk("cc chg2", 8'h00, 8'h6D, 8'h00, 8'h06, pk(5'd1, BL, 5'd5, BL), 1'b0);
        frame_chk("cc chg3", 8'h00, 8'h6D, 8'h00, 8'h06, pk(5'd1, BL, 5'd5, BL), 1'b1);

        // Asynchronous reset in the middle of a partial frame.
        drive(4'b0001, 8'h00, 3);
        drive(4'b0010, 8'h00, 3);
        drive(4'b0100, 8'h00, 2);
        #2;
        rst = 1'b1;
        bus.seg_sel = 4'd0;
        #1;
        chk("midrst disp", 32'(bus.disp_code), 32'h7BDEF);
        chk("midrst frame_valid", 32'(bus.frame_valid), 32'd0);
        chk("midrst stable", 32'(bus.stable), 32'd0);
        chk("midrst sel_err", 32'(bus.sel_err), 32'd0);
        chk("midrst stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        f0 = fv_cnt;
        drive(4'b1000, 8'h06, 1);
        drive(4'b0000, 8'h00, 4);
        chk("partial discarded pulses", 32'(fv_cnt - f0), 32'd0);
        chk("partial discarded disp", 32'(bus.disp_code), 32'h7BDEF);

        // Multi-hot select mid-frame, then a complete frame.
        f0 = fv_cnt;
        e0 = se_cnt;
        drive(4'b0001, 8'h3F, 3);
        drive(4'b0010, 8'h06, 3);
        drive(4'b0011, 8'h00, 1);
        drive(4'b0001, 8'h3F, 3);
        drive(4'b0010, 8'h06, 3);
        drive(4'b0100, 8'h5B, 3);
        chk("selerr pulses", 32'(se_cnt - e0), 32'd1);
        chk("selerr no publish", 32'(fv_cnt - f0), 32'd0);
        chk("selerr disp held", 32'(bus.disp_code), 32'h7BDEF);
        c0 = cyc;
        drive(4'b1000, 8'h4F, 1);
        drive(4'b0000, 8'h00, 4);
        chk("selerr recover pulses", 32'(fv_cnt - f0), 32'd1);
        chk("selerr recover latency", 32'(pub_cyc[f0 % 64] - c0), 32'd3);
        chk("selerr recover disp", 32'(bus.disp_code), 32'(pk(5'd3, 5'd2, 5'd1, 5'd0)));

        frame_chk("pre-stall f2", 8'h3F, 8'h06, 8'h5B, 8'h4F, pk(5'd3, 5'd2, 5'd1, 5'd0), 1'b0);
        frame_chk("pre-stall f3", 8'h3F, 8'h06, 8'h5B, 8'h4F, pk(5'd3, 5'd2, 5'd1, 5'd0), 1'b1);

        // Held select: S1 sees the change one edge later, then 50 idle edges.
        f0 = fv_cnt;
        bus.seg_sel  = 4'b0100;
        bus.seg_data = 8'h00;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (bus.stall) break;
        end
        chk("stall asserted", 32'(bus.stall), 32'd1);
        chk("stall delay", 32'(n), 32'd52);
        chk("stall stable", 32'(bus.stable), 32'd0);
        chk("stall no publish", 32'(fv_cnt - f0), 32'd0);

        drive(4'b0001, 8'h3F, 2);
        chk("stall cleared", 32'(bus.stall), 32'd0);
        drive(4'b0001, 8'h3F, 1);
        drive(4'b0010, 8'h06, 3);
        drive(4'b0100, 8'h5B, 3);
        drive(4'b1000, 8'h4F, 1);
        drive(4'b0000, 8'h00, 4);
        chk("resume pulses", 32'(fv_cnt - f0), 32'd1);
        chk("resume disp", 32'(bus.disp_code), 32'(pk(5'd3, 5'd2, 5'd1, 5'd0)));
        chk("resume stable", 32'(bus.stable), 32'd0);
        frame_chk("resume f2", 8'h3F, 8'h06, 8'h5B, 8'h4F, pk(5'd3, 5'd2, 5'd1, 5'd0), 1'b0);
        frame_chk("resume f3", 8'h3F, 8'h06, 8'h5B, 8'h4F, pk(5'd3, 5'd2, 5'd1, 5'd0), 1'b1);

        // Decode sweep: each pattern visits every digit position once.
        for (int i = 0; i < 21; i++) begin
            f0 = fv_cnt;
            frame(tbl[i].pat, tbl[(i + 1) % 21].pat, tbl[(i + 2) % 21].pat,
                  tbl[(i + 3) % 21].pat, 1);
            chk($sformatf("sweep %0d pulses", i), 32'(fv_cnt - f0), 32'd1);
            chk($sformatf("sweep %0d pat %0h disp", i, tbl[i].pat), 32'(bus.disp_code),
                32'(pk(tbl[(i + 3) % 21].code, tbl[(i + 2) % 21].code,
                       tbl[(i + 1) % 21].code, tbl[i].code)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
